// File: rtl/seg_monitor_if.sv
// Segment monitor bus: sampled segment input, clear, and monitor results.
// master drives iSeg/iClr and observes results; slave is the monitor.
interface seg_monitor_if;
  logic [6:0] iSeg;
  logic       iClr;
  logic [3:0] oDigit;
  logic       oValid;
  logic       oIllegal;
  logic       oSeqErr;
  logic       oLocked;
  logic [7:0] oErrCnt;

  modport master (
    output iSeg, iClr,
    input  oDigit, oValid, oIllegal,
    input  oSeqErr, oLocked, oErrCnt
  );

  modport slave (
    input  iSeg, iClr,
    output oDigit, oValid, oIllegal,
    output oSeqErr, oLocked, oErrCnt
  );
endinterface

// File: rtl/seg_monitor.sv
// 7-segment receive monitor: sync + deglitch an active-low segment bus,
// decode to a digit, check a modulo-MOD up-count, report errors and lock.
// Ports: CLK, RST_n (async low), bus (slave): iSeg, iClr in; oDigit,
// oValid, oIllegal, oSeqErr, oLocked, oErrCnt out.
module seg_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int MOD           = 8
) (
  input logic          CLK,
  input logic          RST_n,
  seg_monitor_if.slave bus
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);
  localparam logic [3:0]    DIG_TOP = 4'(MOD - 1);

  typedef enum logic {IDLE, TRACK} state_t;

  logic [6:0]    r_s1;
  logic [6:0]    r_s2;
  logic [6:0]    r_last;
  logic [RW-1:0] r_run;
  state_t        r_state;
  logic [3:0]    r_digit;
  logic          r_valid;
  logic          r_illegal;
  logic          r_seqerr;
  logic [7:0]    r_errcnt;

  logic       w_acc;
  logic       w_blank;
  logic       w_legal;
  logic [3:0] w_dig;
  logic [3:0] w_exp;
  logic [7:0] w_errinc;

  // Run length of the current s2 value; restarts at 1 when s2 changes.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_s1  <= 7'h7F;
      r_s2  <= 7'h7F;
      r_run <= '0;
    end else begin
      r_s1 <= bus.iSeg;
      r_s2 <= r_s1;
      if (r_s1 != r_s2)
        r_run <= RW'(1);
      else if (r_run != RUN_MAX)
        r_run <= r_run + RW'(1);
    end
  end

  always_comb begin
    w_legal = 1'b1;
    w_dig   = 4'd0;
    case (r_s2)
      7'h40:   w_dig = 4'd0;
      7'h79:   w_dig = 4'd1;
      7'h24:   w_dig = 4'd2;
      7'h30:   w_dig = 4'd3;
      7'h19:   w_dig = 4'd4;
      7'h12:   w_dig = 4'd5;
      7'h02:   w_dig = 4'd6;
      7'h78:   w_dig = 4'd7;
      7'h00:   w_dig = 4'd8;
      7'h10:   w_dig = 4'd9;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_acc    = (r_run == RUN_MAX) && (r_s2 != r_last);
  assign w_blank  = (r_s2 == 7'h7F);
  assign w_exp    = (r_digit == DIG_TOP) ? 4'd0 : r_digit + 4'd1;
  assign w_errinc = (r_errcnt == 8'hFF) ? r_errcnt : r_errcnt + 8'd1;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state   <= IDLE;
      r_last    <= 7'h7F;
      r_digit   <= 4'd0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_seqerr  <= 1'b0;
      r_errcnt  <= 8'd0;
    end else begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_seqerr  <= 1'b0;
      if (bus.iClr) begin
        r_state  <= IDLE;
        r_errcnt <= 8'd0;
        // Swallow a coincident accept so it is not reported later.
        if (w_acc)
          r_last <= r_s2;
      end else if (w_acc) begin
        r_last <= r_s2;
        if (!w_blank) begin
          if (!w_legal) begin
            r_illegal <= 1'b1;
            r_errcnt  <= w_errinc;
            r_state   <= IDLE;
          end else begin
            r_valid <= 1'b1;
            r_digit <= w_dig;
            r_state <= TRACK;
            if (r_state == TRACK && w_dig != w_exp) begin
              r_seqerr <= 1'b1;
              r_errcnt <= w_errinc;
            end
          end
        end
      end
    end
  end

  assign bus.oDigit   = r_digit;
  assign bus.oValid   = r_valid;
  assign bus.oIllegal = r_illegal;
  assign bus.oSeqErr  = r_seqerr;
  assign bus.oLocked  = (r_state == TRACK);
  assign bus.oErrCnt  = r_errcnt;

endmodule
